sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock synchronous FIFO; parametrised successor to the team's fixed 4-bit FIFO.
- Adds:
  - configurable data width and depth;
  - programmable almost-full/almost-empty thresholds;
  - occupancy count;
  - sticky overflow/underflow error flags;
  - synchronous flush;
  - selectable standard or first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer logic in the same clock domain (e.g. sample buffering ahead of display/processing blocks).

Parameters:
- DATA_W, 4, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- w_en  input  1  write request.
- din  input  DATA_W  write data.
- r_en  input  1  read request (standard mode) / pop acknowledge (FWFT).
- flush  input  1  synchronous clear of contents.
- clr_err  input  1  synchronous clear of overflow/underflow.
- dout  output  DATA_W  read data.
- dout_valid  output  1  standard mode: dout updated this cycle. FWFT: dout holds the head word.
- empty  output  1  no entries stored.
- full  output  1  DEPTH entries stored.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full and not accepted.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (async, immediate):
  - pointers = 0, count = 0, empty = 1, full = 0;
  - almost_empty = 1, almost_full = 0;
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0;
  - memory contents don't-care.
- Storage: DEPTH x DATA_W array.
- Pointers: $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty on wrap. Pointers wrap naturally modulo 2*DEPTH.
- Accept rules, evaluated on the pre-edge state:
  - wr_ok = w_en & (!full | rd_ok).
  - rd_ok = r_en & !empty.
  - Write while full is accepted only if a read is accepted in the same cycle; count is unchanged.
  - Read while empty is always rejected, even with a simultaneous write; that write is still accepted.
- count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- All flags are registered and reflect the post-edge count, so they are valid the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On rd_ok, dout <= mem[rd_ptr] and dout_valid = 1 for exactly one cycle. Latency is one clock from the r_en edge.
  - Otherwise dout holds its last value and dout_valid = 0.
- FWFT mode (FWFT=1):
  - dout shows the head entry whenever !empty; dout_valid = !empty.
  - r_en with !empty pops that entry; the next entry (if any) appears after the same edge.
  - A write into an empty FIFO is visible on dout one cycle after the write edge.
- Error flags:
  - overflow sets on w_en & full & !rd_ok.
  - underflow sets on r_en & empty.
  - Both stay set until clr_err or reset.
  - If clr_err coincides with a new error event, the flag stays set.
- flush:
  - Pointers and count go to 0, empty = 1, dout_valid = 0.
  - Flush has priority over w_en/r_en in the same cycle; those requests are ignored and raise no error flags.
  - dout and the error flags are not cleared by flush.
- Reset asserted mid-operation aborts any transfer in progress. Outputs take reset values without waiting for a clock edge.

Test Plan:
- Reset, then write 8 words 0x1..0x8 (DEPTH=8, DATA_W=4) -> count 8, full = 1, almost_full set from count 6. Then read 8 -> dout 0x1..0x8 in order, each one cycle after r_en; empty = 1 at the end.
- Full FIFO, w_en = 1 with din = 0xF and r_en = 0 -> write dropped, overflow = 1, count stays 8. Then clr_err -> overflow = 0.
- Full FIFO, w_en and r_en together for 4 cycles -> count stays 8, full stays 1, no overflow. Data order is preserved across the pointer wrap (16+ total writes).
- Empty FIFO, r_en and w_en together with din = 0xA -> underflow = 1, count = 1, dout_valid = 0. With FWFT=1: dout = 0xA and dout_valid = 1 on the next cycle.
- Load 5 words, assert flush together with w_en -> count = 0, empty = 1, no new data stored, overflow and underflow unchanged.
- Load 3 words, assert reset asynchronously mid-cycle -> all outputs at reset values before the next clk edge. A subsequent write/read of 0x5 returns 0x5.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth, threshold flags, occupancy count,
// sticky error flags, synchronous flush and either registered or fall-through read data.
module sync_fifo_param #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     r_en,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_T   = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T   = PW'(AE_THRESH);
  localparam logic [PW-1:0] FULL_T = PW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic              rd_ok, wr_ok, ovf_evt, udf_evt;
  logic [DATA_W-1:0] dout_nxt;
  logic              dv_nxt;

  // Accept decisions use the registered (pre-edge) flags; flush masks all requests.
  always_comb begin
    rd_ok   = r_en & ~empty & ~flush;
    wr_ok   = w_en & (~full | (r_en & ~empty)) & ~flush;
    ovf_evt = w_en & full & ~(r_en & ~empty) & ~flush;
    udf_evt = r_en & empty & ~flush;

    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      wr_ptr_nxt = wr_ptr + PW'(wr_ok);
      rd_ptr_nxt = rd_ptr + PW'(rd_ok);
      count_nxt  = count + PW'(wr_ok) - PW'(rd_ok);
    end
  end

  // Fall-through mode presents the post-edge head; a word written this cycle into
  // the head slot is not in the array yet, so it is taken straight from din.
  always_comb begin
    dout_nxt = dout;
    dv_nxt   = 1'b0;
    if (FWFT != 0) begin
      if (!flush && count_nxt != '0) begin
        dout_nxt = (wr_ok && rd_ptr_nxt == wr_ptr) ? din : mem[rd_ptr_nxt[AW-1:0]];
        dv_nxt   = 1'b1;
      end
    end else if (rd_ok) begin
      dout_nxt = mem[rd_ptr[AW-1:0]];
      dv_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == FULL_T);
      almost_empty <= (count_nxt <= AE_T);
      almost_full  <= (count_nxt >= AF_T);
      dout         <= dout_nxt;
      dout_valid   <= dv_nxt;
      // A new error event wins over a coincident clear.
      overflow     <= (overflow & ~clr_err) | ovf_evt;
      underflow    <= (underflow & ~clr_err) | udf_evt;
    end
  end

  // NOTE: the storage array has no reset; its contents are only ever read after
  // being written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: drives a standard and a fall-through instance in lockstep
// and compares both against a queue-based model, directed tables and random traffic.
module tb_sync_fifo_param;

  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset, w_en, r_en, flush, clr_err;
  logic [DW-1:0] din;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dv, s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
  logic          f_dv, f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0] s_count, f_count;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .w_en(w_en), .din(din), .r_en(r_en), .flush(flush),
    .clr_err(clr_err), .dout(s_dout), .dout_valid(s_dv), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
    .underflow(s_udf));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fw (
    .clk(clk), .reset(reset), .w_en(w_en), .din(din), .r_en(r_en), .flush(flush),
    .clr_err(clr_err), .dout(f_dout), .dout_valid(f_dv), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_udf));

  always #5 clk = ~clk;

  // Reference model: contents as a queue, errors and read-data registers as plain bits.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_sdv;
  logic [DW-1:0] m_sdout, m_fdout;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 0;
    m_udf   = 0;
    m_sdv   = 0;
    m_sdout = '0;
    m_fdout = '0;
  endtask

  task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r,
                            input bit f, input bit c);
    int  n;
    bit  rd_ok, wr_ok, ovf_e, udf_e;
    n     = q.size();
    rd_ok = !f && r && n > 0;
    wr_ok = !f && w && (n < DEPTH || rd_ok);
    ovf_e = !f && w && n == DEPTH && !rd_ok;
    udf_e = !f && r && n == 0;
    m_sdv = 0;
    if (f) q.delete();
    if (rd_ok) begin
      m_sdout = q.pop_front();
      m_sdv   = 1;
    end
    if (wr_ok) q.push_back(d);
    if (q.size() > 0) m_fdout = q[0];
    m_ovf = (m_ovf && !c) || ovf_e;
    m_udf = (m_udf && !c) || udf_e;
  endtask

  task automatic compare_all(input string tag);
    int n;
    n = q.size();
    check({tag, " s.count"}, s_count, n);
    check({tag, " s.empty"}, s_empty, int'(n == 0));
    check({tag, " s.full"},  s_full,  int'(n == DEPTH));
    check({tag, " s.af"},    s_af,    int'(n >= DEPTH - 2));
    check({tag, " s.ae"},    s_ae,    int'(n <= 2));
    check({tag, " s.ovf"},   s_ovf,   int'(m_ovf));
    check({tag, " s.udf"},   s_udf,   int'(m_udf));
    check({tag, " s.dv"},    s_dv,    int'(m_sdv));
    check({tag, " s.dout"},  s_dout,  m_sdout);
    check({tag, " f.count"}, f_count, n);
    check({tag, " f.empty"}, f_empty, int'(n == 0));
    check({tag, " f.ovf"},   f_ovf,   int'(m_ovf));
    check({tag, " f.udf"},   f_udf,   int'(m_udf));
    check({tag, " f.dv"},    f_dv,    int'(n != 0));
    check({tag, " f.dout"},  f_dout,  m_fdout);
  endtask

  // One clock: inputs applied after the falling edge, outputs compared 1 ns after the rising edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f,
                      input bit c, input string tag);
    w_en = w; din = d; r_en = r; flush = f; clr_err = c;
    @(posedge clk);
    model_edge(w, d, r, f, c);
    #1;
    compare_all(tag);
    @(negedge clk);
    w_en = 0; r_en = 0; flush = 0; clr_err = 0;
  endtask

  typedef struct {
    bit            w;
    logic [DW-1:0] d;
    bit            r;
    bit            f;
    bit            c;
    int            e_count;
    bit            e_udf;
    bit            e_sdv;
    bit            e_fdv;
    logic [DW-1:0] e_fdout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Read on empty, clear, read+write on empty, pop with clear, flush over a write,
    // then a clear that coincides with a fresh underflow.
    vecs[0] = '{w:0, d:4'h0, r:1, f:0, c:0, e_count:0, e_udf:1, e_sdv:0, e_fdv:0, e_fdout:4'h0};
    vecs[1] = '{w:0, d:4'h0, r:0, f:0, c:1, e_count:0, e_udf:0, e_sdv:0, e_fdv:0, e_fdout:4'h0};
    vecs[2] = '{w:1, d:4'hA, r:1, f:0, c:0, e_count:1, e_udf:1, e_sdv:0, e_fdv:1, e_fdout:4'hA};
    vecs[3] = '{w:0, d:4'h0, r:1, f:0, c:1, e_count:0, e_udf:0, e_sdv:1, e_fdv:0, e_fdout:4'hA};
    vecs[4] = '{w:1, d:4'h3, r:0, f:0, c:0, e_count:1, e_udf:0, e_sdv:0, e_fdv:1, e_fdout:4'h3};
    vecs[5] = '{w:1, d:4'h4, r:0, f:1, c:0, e_count:0, e_udf:0, e_sdv:0, e_fdv:0, e_fdout:4'h3};
    vecs[6] = '{w:0, d:4'h0, r:1, f:0, c:1, e_count:0, e_udf:1, e_sdv:0, e_fdv:0, e_fdout:4'h3};

    reset = 1; w_en = 0; r_en = 0; flush = 0; clr_err = 0; din = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    reset = 0;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d count", i), s_count, vecs[i].e_count);
      check($sformatf("vec%0d udf", i),   s_udf,   int'(vecs[i].e_udf));
      check($sformatf("vec%0d s.dv", i),  s_dv,    int'(vecs[i].e_sdv));
      check($sformatf("vec%0d f.dv", i),  f_dv,    int'(vecs[i].e_fdv));
      check($sformatf("vec%0d f.dout", i), f_dout, vecs[i].e_fdout);
    end
    check("vec3 s.dout", s_dout, 4'hA);
    step(0, 0, 0, 0, 1, "clr");

    // Fill with 1..8, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, DW'(i), 0, 0, 0, "fill");
      check($sformatf("fill%0d af", i), s_af, int'(i >= 6));
    end
    check("fill full", s_full, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 1, 0, 0, "drain");
      check($sformatf("drain%0d data", i), s_dout, i);
    end
    check("drain empty", s_empty, 1);

    // Overflow on a full FIFO, then clear it.
    for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0, 0, 0, "refill");
    step(1, 4'hF, 0, 0, 0, "ovf");
    check("ovf flag", s_ovf, 1);
    check("ovf count", s_count, DEPTH);
    step(0, 0, 0, 0, 1, "ovf clr");
    check("ovf cleared", s_ovf, 0);

    // Simultaneous read and write while full, data order kept across the wrap.
    for (int i = 0; i < 4; i++) begin
      step(1, DW'(9 + i), 1, 0, 0, "rw full");
      check("rw full count", s_count, DEPTH);
      check("rw full no ovf", s_ovf, 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, 0, "wrap drain");
      check($sformatf("wrap drain%0d", i), s_dout, 5 + i);
    end

    // Flush over a write with underflow already set.
    step(0, 0, 1, 0, 0, "pre-flush udf");
    for (int i = 0; i < 5; i++) step(1, DW'(i + 2), 0, 0, 0, "load5");
    step(1, 4'h7, 0, 1, 0, "flush");
    check("flush count", s_count, 0);
    check("flush udf kept", s_udf, 1);
    check("flush f.dv", f_dv, 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) step(1, DW'(i + 1), 0, 0, 0, "load3");
    #2 reset = 1;
    #1;
    model_reset();
    compare_all("async rst");
    check("async rst ae", s_ae, 1);
    check("async rst af", f_af, 0);
    @(negedge clk);
    reset = 0;
    step(1, 4'h5, 0, 0, 0, "post rst wr");
    check("post rst f.dout", f_dout, 5);
    step(0, 0, 1, 0, 0, "post rst rd");
    check("post rst s.dout", s_dout, 5);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
